// File: rtl/sqrt_pipe_if.sv
// Operand/result bundle for sqrt_pipe: radicand in, floor root and remainder out.
// Optional SQRT_EXACT_FLAG_EN adds the perfect-square flag 'exact'.
interface sqrt_pipe_if #(
  parameter int DATA_WIDTH = 21
);
  localparam int Q_WIDTH   = (DATA_WIDTH + 1) / 2;
  localparam int REM_WIDTH = Q_WIDTH + 1;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] radical;
  logic                  out_valid;
  logic [Q_WIDTH-1:0]    q;
  logic [REM_WIDTH-1:0]  remainder;
`ifdef SQRT_EXACT_FLAG_EN
  logic                  exact;
`endif

  modport master (
    output in_valid,
    output radical,
    input  out_valid,
    input  q,
`ifdef SQRT_EXACT_FLAG_EN
    input  exact,
`endif
    input  remainder
  );

  modport slave (
    input  in_valid,
    input  radical,
    output out_valid,
    output q,
`ifdef SQRT_EXACT_FLAG_EN
    output exact,
`endif
    output remainder
  );
endinterface

// File: rtl/sqrt_pipe.sv
// Fully pipelined restoring binary square root, one root bit per stage, MSB first.
// Optional macro SQRT_EXACT_FLAG_EN adds a registered perfect-square flag.
module sqrt_pipe #(
  parameter int DATA_WIDTH = 21
) (
  input  logic       clk_main,
  input  logic       sys_rst,
  sqrt_pipe_if.slave bus
);
  localparam int Q_WIDTH    = (DATA_WIDTH + 1) / 2;
  localparam int REM_WIDTH  = Q_WIDTH + 1;
  localparam int PAD_WIDTH  = 2 * Q_WIDTH;
  localparam int STEP_WIDTH = Q_WIDTH + REM_WIDTH;

  // One digit step: returns {next root, next partial remainder}.
  function automatic logic [STEP_WIDTH-1:0] sqrt_step(
    input logic [REM_WIDTH-1:0] rem,
    input logic [Q_WIDTH-1:0]   root,
    input logic [1:0]           pair
  );
    logic [REM_WIDTH+1:0] cand;
    logic [REM_WIDTH+1:0] sub;
    logic [Q_WIDTH-1:0]   root_zero;
    logic [Q_WIDTH-1:0]   root_one;
    cand      = {rem, pair};
    sub       = {1'b0, root, 2'b01};
    root_zero = root << 1'b1;
    root_one  = root_zero | Q_WIDTH'(1'b1);
    if (cand >= sub) begin
      return {root_one, REM_WIDTH'(cand - sub)};
    end else begin
      return {root_zero, REM_WIDTH'(cand)};
    end
  endfunction

  logic [PAD_WIDTH-1:0] rad_pad_s;
  assign rad_pad_s = PAD_WIDTH'(bus.radical);

  // Stage k sees the 2*(Q_WIDTH-k) radicand bits not yet consumed and forwards the rest.
  for (genvar k = 0; k < Q_WIDTH; k++) begin : g_stage
    localparam int IN_W = 2 * (Q_WIDTH - k);

    logic [IN_W-1:0]       rad_s;
    logic [REM_WIDTH-1:0]  rem_s;
    logic [Q_WIDTH-1:0]    root_s;
    logic                  vld_s;
    logic [STEP_WIDTH-1:0] step_s;
    logic [REM_WIDTH-1:0]  rem_d;
    logic [REM_WIDTH-1:0]  rem_q;
    logic [Q_WIDTH-1:0]    root_d;
    logic [Q_WIDTH-1:0]    root_q;
    logic                  vld_q;

    if (k == 0) begin : g_head
      assign rad_s  = rad_pad_s;
      assign rem_s  = {REM_WIDTH{1'b0}};
      assign root_s = {Q_WIDTH{1'b0}};
      assign vld_s  = bus.in_valid;
    end else begin : g_body
      assign rad_s  = g_stage[k-1].g_fwd.rad_q;
      assign rem_s  = g_stage[k-1].rem_q;
      assign root_s = g_stage[k-1].root_q;
      assign vld_s  = g_stage[k-1].vld_q;
    end

    assign step_s = sqrt_step(rem_s, root_s, rad_s[IN_W-1 -: 2]);
    assign root_d = step_s[REM_WIDTH +: Q_WIDTH];
    assign rem_d  = step_s[0 +: REM_WIDTH];

    // Partial root/remainder and valid bit advance every cycle.
    always_ff @(posedge clk_main) begin
      if (sys_rst) begin
        rem_q  <= {REM_WIDTH{1'b0}};
        root_q <= {Q_WIDTH{1'b0}};
        vld_q  <= 1'b0;
      end else begin
        rem_q  <= rem_d;
        root_q <= root_d;
        vld_q  <= vld_s;
      end
    end

    if (k < Q_WIDTH - 1) begin : g_fwd
      logic [IN_W-3:0] rad_q;

      // Remaining radicand bits for the following stage.
      always_ff @(posedge clk_main) begin
        if (sys_rst) begin
          rad_q <= {(IN_W-2){1'b0}};
        end else begin
          rad_q <= rad_s[IN_W-3:0];
        end
      end
    end
  end

  logic                 out_valid_q;
  logic [Q_WIDTH-1:0]   res_q_q;
  logic [REM_WIDTH-1:0] res_rem_q;

  // Result registers load only when the last stage carries a valid operand.
  always_ff @(posedge clk_main) begin
    if (sys_rst) begin
      out_valid_q <= 1'b0;
      res_q_q     <= {Q_WIDTH{1'b0}};
      res_rem_q   <= {REM_WIDTH{1'b0}};
    end else begin
      out_valid_q <= g_stage[Q_WIDTH-1].vld_q;
      if (g_stage[Q_WIDTH-1].vld_q) begin
        res_q_q   <= g_stage[Q_WIDTH-1].root_q;
        res_rem_q <= g_stage[Q_WIDTH-1].rem_q;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.q         = res_q_q;
  assign bus.remainder = res_rem_q;

`ifdef SQRT_EXACT_FLAG_EN
  logic exact_q;

  // Perfect-square flag tracks the result registers.
  always_ff @(posedge clk_main) begin
    if (sys_rst) begin
      exact_q <= 1'b0;
    end else if (g_stage[Q_WIDTH-1].vld_q) begin
      exact_q <= (g_stage[Q_WIDTH-1].rem_q == {REM_WIDTH{1'b0}});
    end else begin
      exact_q <= exact_q;
    end
  end

  assign bus.exact = exact_q;
`endif
endmodule

// File: tb/tb_sqrt_pipe.sv
// Self-checking bench for sqrt_pipe: directed boundaries, streaming, random sweep and
// mid-stream reset, checked against an arithmetic floor-sqrt model and an issue queue.
module tb_sqrt_pipe;
  localparam int DW = 21;
  localparam int QW = (DW + 1) / 2;

  logic clk_main = 1'b0;
  logic sys_rst;

  always #5 clk_main = ~clk_main;

  sqrt_pipe_if #(.DATA_WIDTH(DW)) bus ();

  sqrt_pipe #(.DATA_WIDTH(DW)) u_dut (
    .clk_main (clk_main),
    .sys_rst  (sys_rst),
    .bus      (bus)
  );

  typedef struct packed {
    logic [31:0] rad;
    logic [31:0] cyc;
  } op_t;

  op_t         exp_q[$];
  int unsigned cyc        = 0;
  int          n_vec      = 0;
  int          n_err      = 0;
  int unsigned last_q     = 0;
  int unsigned last_rem   = 0;
  logic        last_exact = 1'b0;

  function automatic int unsigned isqrt(input int unsigned r);
    longint unsigned s;
    longint unsigned rl;
    rl = longint'(r);
    s  = longint'($sqrt(real'(r)));
    while (s * s > rl) s = s - 1;
    while ((s + 1) * (s + 1) <= rl) s = s + 1;
    return s[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] r);
    bus.in_valid = v;
    bus.radical  = r;
    @(posedge clk_main);
    #1;
  endtask

  // Issue log: every accepted operand is queued; reset discards everything in flight.
  always @(posedge clk_main) begin
    op_t o;
    cyc++;
    if (sys_rst) begin
      exp_q.delete();
      last_q     = 0;
      last_rem   = 0;
      last_exact = 1'b0;
    end else if (bus.in_valid) begin
      o.rad = 32'(bus.radical);
      o.cyc = cyc;
      exp_q.push_back(o);
    end
  end

  // Result monitor: order, latency, value, and hold behaviour between results.
  always @(negedge clk_main) begin
    op_t         o;
    int unsigned eq;
    int unsigned erem;
    if (cyc != 0) begin
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          o    = exp_q.pop_front();
          eq   = isqrt(o.rad);
          erem = o.rad - eq * eq;
          check("latency", 64'(cyc - o.cyc), 64'(QW));
          check("q", 64'(bus.q), 64'(eq));
          check("remainder", 64'(bus.remainder), 64'(erem));
`ifdef SQRT_EXACT_FLAG_EN
          check("exact", 64'(bus.exact), 64'(erem == 0));
          last_exact = (erem == 0);
`endif
          last_q   = eq;
          last_rem = erem;
        end
      end else begin
        check("out_valid_low", 64'(bus.out_valid), 64'd0);
        check("hold_q", 64'(bus.q), 64'(last_q));
        check("hold_rem", 64'(bus.remainder), 64'(last_rem));
`ifdef SQRT_EXACT_FLAG_EN
        check("hold_exact", 64'(bus.exact), 64'(last_exact));
`endif
      end
    end
  end

  logic [DW-1:0] bnd [5];

  initial begin
    bnd[0] = 21'd0;
    bnd[1] = 21'd4;
    bnd[2] = 21'd3;
    bnd[3] = 21'd2097151;
    bnd[4] = 21'd2096704;

    // Reset held with a live operand on the input: nothing may come out.
    sys_rst      = 1'b1;
    bus.in_valid = 1'b1;
    bus.radical  = 21'd100;
    repeat (5) @(posedge clk_main);
    @(negedge clk_main);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_q", 64'(bus.q), 64'd0);
    check("rst_rem", 64'(bus.remainder), 64'd0);
    sys_rst      = 1'b0;
    bus.in_valid = 1'b0;
    repeat (QW + 1) drive(1'b0, 21'd0);

    // Single operand, exact latency, then one-cycle pulse with held data.
    drive(1'b1, 21'd103);
    repeat (QW) drive(1'b0, 21'd0);
    @(negedge clk_main);
    check("single_valid", 64'(bus.out_valid), 64'd1);
    check("single_q", 64'(bus.q), 64'd10);
    check("single_rem", 64'(bus.remainder), 64'd3);
    drive(1'b0, 21'd0);
    @(negedge clk_main);
    check("single_pulse", 64'(bus.out_valid), 64'd0);
    check("single_hold_q", 64'(bus.q), 64'd10);
    check("single_hold_rem", 64'(bus.remainder), 64'd3);

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, bnd[i]);
      drive(1'b0, 21'd0);
    end
    repeat (QW + 2) drive(1'b0, 21'd0);

    for (int a = 0; a <= 1000; a++) begin
      drive(1'b1, DW'(a * a + 3));
    end
    repeat (QW + 2) drive(1'b0, 21'd0);

    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(0, 3) != 0), DW'($urandom));
    end
    repeat (QW + 2) drive(1'b0, 21'd0);

    // Mid-stream reset after the 8th operand; the input stays valid through it.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, DW'($urandom));
      if (i == 7) begin
        sys_rst = 1'b1;
        drive(1'b1, DW'($urandom));
        sys_rst = 1'b0;
      end
    end
    repeat (QW + 4) drive(1'b0, 21'd0);

    check("drain_all_results", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
